// File: rtl/fifo_unpack_pkg.sv
// Shared types and helpers for fifo_unpack: FSM state type, counter sizing
// and the beat-index mapping that implements LSB-first / MSB-first slicing.
package fifo_unpack_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } fifo_unpack_state_e;

   // Bits needed to hold values 0..value-1 (at least 1 bit).
   function automatic int unsigned vbits(input int unsigned value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

   // Which OutWidth-wide slice of the held word is emitted as beat 'cnt'.
   // LSB-first: beat 0 is slice 0; MSB-first: beat 0 is the top slice.
   function automatic int unsigned beat_idx(input int unsigned cnt,
                                            input int unsigned ratio,
                                            input bit          msb_first);
      return msb_first ? (ratio - 1 - cnt) : cnt;
   endfunction

endpackage

// File: rtl/fifo_unpack.sv
// fifo_unpack: pops InWidth-bit words from a FIFO read port and replays each
// as Ratio = InWidth/OutWidth narrow beats on a valid/ready output, one beat
// per cycle with no bubble between consecutive words.
// InWidth must be an integer multiple of OutWidth with Ratio >= 2.
// Optional feature: define FIFO_UNPACK_PARTIAL_EN to add in_beats_i, giving a
// per-word beat count (0 or > Ratio means a full word).
module fifo_unpack
   import fifo_unpack_pkg::*;
#(
   parameter int unsigned InWidth  = 32,
   parameter int unsigned OutWidth = 8,
   parameter bit          MsbFirst = 1'b0,
   localparam int unsigned Ratio   = InWidth / OutWidth,
   localparam int unsigned CntW    = fifo_unpack_pkg::vbits(Ratio + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clr_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [InWidth-1:0]  in_data_i,
`ifdef FIFO_UNPACK_PARTIAL_EN
   input  logic [CntW-1:0]     in_beats_i,
`endif
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [OutWidth-1:0] out_data_o,
   output logic                out_last_o,
   output logic                busy_o
);

   localparam logic [CntW-1:0] RatioBeats = CntW'(Ratio);

   fifo_unpack_state_e state_q, state_d;
   logic [InWidth-1:0] data_q, data_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [CntW-1:0]    num_beats;
   logic [31:0]        cnt_ext;
   logic               under_rst_q;
   logic               last_beat;
   logic               beat_fire;
   logic               word_fire;

`ifdef FIFO_UNPACK_PARTIAL_EN
   logic [CntW-1:0]    num_q, num_d;
   assign num_beats = num_q;
`else
   assign num_beats = RatioBeats;
`endif

   // Handshake and output decode; everything derives from registered state
   // so the first beat of a word appears one cycle after the pop.
   assign busy_o      = (state_q == SHIFT);
   assign out_valid_o = busy_o & ~under_rst_q;
   assign last_beat   = busy_o & (cnt_q == num_beats - 1'b1);
   assign out_last_o  = last_beat;
   assign beat_fire   = out_valid_o & out_ready_i;
   // Pop only when empty, or when the last beat leaves this cycle (no bubble);
   // a flush cycle never pops.
   assign in_ready_o  = ~under_rst_q & ~clr_i & (~busy_o | (beat_fire & last_beat));
   assign word_fire   = in_valid_i & in_ready_o;

   assign cnt_ext     = 32'(cnt_q);
   assign out_data_o  = busy_o
      ? OutWidth'(data_q >> (OutWidth * beat_idx(cnt_ext, Ratio, MsbFirst)))
      : '0;

   // Next-state: flush beats word load beats beat advance.
   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path can
      // leave it unassigned and infer a latch.
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      if (clr_i) begin
         state_d = IDLE;
         data_d  = '0;
         cnt_d   = '0;
      end else if (word_fire) begin
         state_d = SHIFT;
         data_d  = in_data_i;
         cnt_d   = '0;
      end else if (beat_fire) begin
         if (last_beat) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

`ifdef FIFO_UNPACK_PARTIAL_EN
   // Capture the word's beat count; out-of-range counts mean a full word.
   always_comb begin
      num_d = num_q;
      if (!clr_i && word_fire) begin
         if (in_beats_i == '0 || in_beats_i > RatioBeats) begin
            num_d = RatioBeats;
         end else begin
            num_d = in_beats_i;
         end
      end
   end

   // Beat-count register; resets to a full word so num_q-1 never underflows.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         num_q <= RatioBeats;
      end else begin
         num_q <= num_d;
      end
   end
`endif

   // State registers; under_rst_q holds off both ports for the first cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: the held word is a plain register, not a memory array, so
         // clearing it in reset is cheap and keeps out_data_o deterministic.
         state_q     <= IDLE;
         data_q      <= '0;
         cnt_q       <= '0;
         under_rst_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         data_q      <= data_d;
         cnt_q       <= cnt_d;
         under_rst_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_unpack.sv
// Scoreboard bench for fifo_unpack. Two instances (LSB-first and MSB-first)
// share stimulus; a reference model expands each accepted word into its
// expected beat list, and a monitor compares every cycle on the falling edge.
`timescale 1ns/1ps
module tb_fifo_unpack;
   import fifo_unpack_pkg::*;

   localparam int IN_W  = 32;
   localparam int OUT_W = 8;
   localparam int RATIO = IN_W / OUT_W;
   localparam int CNT_W = vbits(RATIO + 1);

   typedef struct {
      logic [OUT_W-1:0] data;
      logic             last;
   } beat_t;

   logic             clk_i       = 1'b0;
   logic             rst_ni      = 1'b0;
   logic             clr_i       = 1'b0;
   logic             in_valid_i  = 1'b0;
   logic             out_ready_i = 1'b1;
   logic [IN_W-1:0]  in_data_i   = '0;
`ifdef FIFO_UNPACK_PARTIAL_EN
   logic [CNT_W-1:0] in_beats_i  = '0;
`endif
   logic             in_ready  [2];
   logic             out_valid [2];
   logic             out_last  [2];
   logic             busy      [2];
   logic [OUT_W-1:0] out_data  [2];

   int    n_tests     = 0;
   int    n_fail      = 0;
   int    rdy_mode    = 0;   // 0: always ready, 1: toggle, 2: random
   logic  m_under_rst = 1'b1;
   beat_t sb [2][$];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      fifo_unpack #(
         .InWidth (IN_W),
         .OutWidth(OUT_W),
         .MsbFirst(g == 1)
      ) u_dut (
         .clk_i      (clk_i),
         .rst_ni     (rst_ni),
         .clr_i      (clr_i),
         .in_valid_i (in_valid_i),
         .in_ready_o (in_ready[g]),
         .in_data_i  (in_data_i),
`ifdef FIFO_UNPACK_PARTIAL_EN
         .in_beats_i (in_beats_i),
`endif
         .out_valid_o(out_valid[g]),
         .out_ready_i(out_ready_i),
         .out_data_o (out_data[g]),
         .out_last_o (out_last[g]),
         .busy_o     (busy[g])
      );
   end

   always #5 clk_i = ~clk_i;

   // Model of the post-reset hold-off: one cycle after release.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) m_under_rst <= 1'b1;
      else         m_under_rst <= 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   // Reference model: expand a word into its beat list for instance g.
   task automatic push_word(input int g, input logic [IN_W-1:0] w, input int beats);
      int    n;
      int    k;
      beat_t b;
      n = (beats == 0 || beats > RATIO) ? RATIO : beats;
      for (int i = 0; i < n; i++) begin
         k      = (g == 1) ? (RATIO - 1 - i) : i;
         b.data = OUT_W'(w >> (OUT_W * k));
         b.last = (i == n - 1);
         sb[g].push_back(b);
      end
   endtask

   task automatic monitor_dut(input int g);
      beat_t            fr;
      logic             exp_valid;
      logic             exp_ready;
      logic [OUT_W-1:0] exp_data;
      logic             exp_last;
      int               beats;
      if (!rst_ni) begin
         check($sformatf("d%0d_rst_out_valid", g), out_valid[g], 0);
         check($sformatf("d%0d_rst_in_ready", g),  in_ready[g],  0);
         check($sformatf("d%0d_rst_busy", g),      busy[g],      0);
         check($sformatf("d%0d_rst_out_data", g),  out_data[g],  0);
         check($sformatf("d%0d_rst_out_last", g),  out_last[g],  0);
         sb[g].delete();
         return;
      end
      fr.data   = '0;
      fr.last   = 1'b0;
      exp_valid = (sb[g].size() != 0);
      if (exp_valid) fr = sb[g][0];
      exp_data  = fr.data;
      exp_last  = fr.last;
      exp_ready = !m_under_rst && !clr_i && (!exp_valid || (out_ready_i && fr.last));
      check($sformatf("d%0d_out_valid", g), out_valid[g], exp_valid);
      check($sformatf("d%0d_busy", g),      busy[g],      exp_valid);
      check($sformatf("d%0d_out_data", g),  out_data[g],  exp_data);
      check($sformatf("d%0d_out_last", g),  out_last[g],  exp_last);
      check($sformatf("d%0d_in_ready", g),  in_ready[g],  exp_ready);
      if (clr_i) begin
         sb[g].delete();
         return;
      end
      if (exp_valid && out_ready_i) void'(sb[g].pop_front());
`ifdef FIFO_UNPACK_PARTIAL_EN
      beats = int'(in_beats_i);
`else
      beats = RATIO;
`endif
      if (in_valid_i && exp_ready) push_word(g, in_data_i, beats);
   endtask

   always @(negedge clk_i) begin
      for (int g = 0; g < 2; g++) monitor_dut(g);
   end

   // Downstream ready pattern, updated just after each rising edge.
   always @(posedge clk_i) begin
      #1;
      case (rdy_mode)
         0:       out_ready_i = 1'b1;
         1:       out_ready_i = ~out_ready_i;
         default: out_ready_i = 1'($urandom_range(0, 1));
      endcase
   end

   // Present a word and hold it until popped; returns just after the pop edge.
   task automatic send_word(input logic [IN_W-1:0] w, input int beats);
      int t = 0;
      in_valid_i = 1'b1;
      in_data_i  = w;
`ifdef FIFO_UNPACK_PARTIAL_EN
      in_beats_i = CNT_W'(beats);
`endif
      do begin
         @(negedge clk_i);
         t++;
      end while (!in_ready[0] && t < 200);
      if (!in_ready[0]) fail_timeout("send_word");
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((sb[0].size() != 0 || sb[1].size() != 0) && t < 500) begin
         @(posedge clk_i);
         #1;
         t++;
      end
      if (sb[0].size() != 0 || sb[1].size() != 0) fail_timeout("drain");
      repeat (2) @(posedge clk_i);
      #1;
   endtask

   initial begin
      // Word held on the input through reset; no pop in the hold-off cycle.
      in_valid_i = 1'b1;
      in_data_i  = 32'hA1B2C3D4;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      check("under_rst_in_ready", in_ready[0], 0);
      check("under_rst_out_valid", out_valid[0], 0);
      send_word(32'hA1B2C3D4, RATIO);
      drain();

      // Back-to-back words with no bubble.
      send_word(32'h11223344, RATIO);
      send_word(32'h55667788, RATIO);
      drain();

      // Alternating downstream stalls.
      rdy_mode = 1;
      send_word(32'h0F1E2D3C, RATIO);
      send_word(32'h4B5A6978, RATIO);
      drain();
      rdy_mode = 0;

      // Flush after the second beat, with the next word waiting.
      send_word(32'hDEADBEEF, RATIO);
      repeat (2) begin
         @(posedge clk_i);
         #1;
      end
      clr_i      = 1'b1;
      in_valid_i = 1'b1;
      in_data_i  = 32'h0BADF00D;
      @(posedge clk_i);
      #1;
      clr_i = 1'b0;
      check("clr_out_valid", out_valid[0], 0);
      check("clr_busy0", busy[0], 0);
      check("clr_busy1", busy[1], 0);
      send_word(32'h0BADF00D, RATIO);
      drain();

`ifdef FIFO_UNPACK_PARTIAL_EN
      // Partial words: two beats, then 0 meaning a full word, then one beat.
      send_word(32'hCAFEBABE, 2);
      send_word(32'h76543210, 0);
      send_word(32'h89ABCDEF, 1);
      drain();
`endif

      // Randomized words, gaps and downstream backpressure.
      rdy_mode = 2;
      for (int i = 0; i < 150; i++) begin
`ifdef FIFO_UNPACK_PARTIAL_EN
         send_word($urandom, int'($urandom_range(0, 7)));
`else
         send_word($urandom, RATIO);
`endif
         repeat ($urandom_range(0, 2)) @(posedge clk_i);
         #1;
      end
      drain();
      rdy_mode = 0;

      // Reset mid-word: the word is lost and outputs drop at once.
      send_word(32'hFEEDC0DE, RATIO);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      #1;
      check("rstmid_out_valid", out_valid[0], 0);
      check("rstmid_out_data", out_data[0], 0);
      check("rstmid_busy", busy[0], 0);
      check("rstmid_in_ready", in_ready[0], 0);
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      send_word(32'h12345678, RATIO);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
